uart_rx_fifo: RTL and testbench

- Receive-side byte buffer sitting directly downstream of the UART receiver.
- Captures each completed byte on the receiver's one-cycle done strobe and holds it in a DEPTH-entry circular FIFO until the MIC-1 side pops it.
- Decouples serial arrival timing from the consumer and flags lost bytes with a sticky overrun status.

---
 rtl/uart_rx_fifo.sv | 83 ++++++++
 tb/tb_uart_rx_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: captures bytes on rx_done,
// presents the head byte first-word-fall-through, and flags dropped bytes.
module uart_rx_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_done,
  input  logic          rd_en,
  input  logic          ovr_clr,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overrun
);

  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_accept;
  logic          rd_accept;
  logic          drop;

  // Flags come only from the registered count, so no input reaches them combinationally.
  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  // A pop while full frees the slot this same edge, so the write is still accepted.
  assign rd_accept = rd_en && !empty;
  assign wr_accept = rx_done && (!full || rd_en);
  assign drop      = rx_done && full && !rd_en;

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      unique case ({wr_accept, rd_accept})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A new drop outranks a clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed vector table, hand-written
// corner sequences, and a randomized run against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_done;
  logic          rd_en;
  logic          ovr_clr;
  logic [7:0]    rd_data;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overrun;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_data (rx_data),
    .rx_done (rx_done),
    .rd_en   (rd_en),
    .ovr_clr (ovr_clr),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .overrun (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Reference model: the FIFO contents as a plain queue plus the sticky flag.
  logic [7:0] model_q[$];
  logic       model_ovr = 1'b0;

  typedef struct {
    logic       rst;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       rd_en;
    logic       ovr_clr;
    int         exp_count;
    logic       exp_empty;
    logic       exp_full;
    logic       exp_ovr;
    logic       chk_data;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs, advances the model by the FIFO's rules, and
  // leaves the bench 1ns after the edge so outputs can be sampled.
  task automatic apply_stimulus(input logic r, input logic done, input logic [7:0] data,
                                input logic rd, input logic clr);
    int  size;
    logic do_rd;
    logic do_wr;
    rst = r; rx_done = done; rx_data = data; rd_en = rd; ovr_clr = clr;
    size = model_q.size();
    if (r) begin
      model_q.delete();
      model_ovr = 1'b0;
    end else begin
      do_rd = rd && (size > 0);
      do_wr = done && ((size < DEPTH) || rd);
      if (do_rd) void'(model_q.pop_front());
      if (do_wr) model_q.push_back(data);
      if (done && (size == DEPTH) && !rd) model_ovr = 1'b1;
      else if (clr) model_ovr = 1'b0;
    end
    @(posedge clk);
    #1;
    rst = 1'b0; rx_done = 1'b0; rd_en = 1'b0; ovr_clr = 1'b0;
  endtask

  task automatic check_output();
    check("count", int'(count), model_q.size());
    check("empty", int'(empty), int'(model_q.size() == 0));
    check("full", int'(full), int'(model_q.size() == DEPTH));
    check("overrun", int'(overrun), int'(model_ovr));
    if (model_q.size() > 0) check("rd_data", int'(rd_data), int'(model_q[0]));
  endtask

  task automatic push(input logic [7:0] d);
    apply_stimulus(1'b0, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic pop();
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; rx_done = 1'b0; rx_data = 8'h00; rd_en = 1'b0; ovr_clr = 1'b0;

    // Directed vector table: basic push/pop, empty-read and empty write+read.
    vecs.push_back(vec_t'{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    vecs.push_back(vec_t'{1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41});
    vecs.push_back(vec_t'{1'b0, 1'b1, 8'h42, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41});
    vecs.push_back(vec_t'{1'b0, 1'b1, 8'h43, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41});
    vecs.push_back(vec_t'{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h42});
    vecs.push_back(vec_t'{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h43});
    vecs.push_back(vec_t'{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    vecs.push_back(vec_t'{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    vecs.push_back(vec_t'{1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55});
    vecs.push_back(vec_t'{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].rst, vecs[i].rx_done, vecs[i].rx_data, vecs[i].rd_en, vecs[i].ovr_clr);
      check($sformatf("vec%0d.count", i), int'(count), vecs[i].exp_count);
      check($sformatf("vec%0d.empty", i), int'(empty), int'(vecs[i].exp_empty));
      check($sformatf("vec%0d.full", i), int'(full), int'(vecs[i].exp_full));
      check($sformatf("vec%0d.overrun", i), int'(overrun), int'(vecs[i].exp_ovr));
      if (vecs[i].chk_data) check($sformatf("vec%0d.rd_data", i), int'(rd_data), int'(vecs[i].exp_data));
    end

    // Fill to full, drop a byte, then drain in order.
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    check("fill.full", int'(full), 1);
    check("fill.count", int'(count), DEPTH);
    push(8'hFF);
    check("drop.overrun", int'(overrun), 1);
    check("drop.count", int'(count), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain%0d", i), int'(rd_data), i);
      pop();
    end
    check("drain.empty", int'(empty), 1);
    check("drain.overrun_held", int'(overrun), 1);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("ovr_clr", int'(overrun), 0);

    // Simultaneous write and pop while full.
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i));
    apply_stimulus(1'b0, 1'b1, 8'hAA, 1'b1, 1'b0);
    check("fullrw.count", int'(count), DEPTH);
    check("fullrw.overrun", int'(overrun), 0);
    check("fullrw.head", int'(rd_data), 8'h11);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check("fullrw.last", int'(rd_data), 8'hAA);
      pop();
    end
    check("fullrw.empty", int'(empty), 1);

    // Pointer wrap-around with interleaved push/pop pairs.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      push(8'(8'h80 + i));
      check("wrap.count1", int'(count), 1);
      check("wrap.data", int'(rd_data), (8'h80 + i) & 8'hFF);
      pop();
      check("wrap.count0", int'(count), 0);
    end

    // Reset in the middle of a stream with rx_done asserted in the reset cycle.
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(8'(8'h20 + i));
    push(8'hEE);
    check("rstmid.ovr_set", int'(overrun), 1);
    apply_stimulus(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
    check("rstmid.count", int'(count), 0);
    check("rstmid.empty", int'(empty), 1);
    check("rstmid.overrun", int'(overrun), 0);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("rstmid.not_stored", int'(count), 0);

    // Clear and drop in the same cycle: the drop wins.
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    apply_stimulus(1'b0, 1'b1, 8'h77, 1'b0, 1'b1);
    check("clr_vs_drop", int'(overrun), 1);
    check_output();

    // Randomized run against the reference model, with phases biased toward
    // filling and draining so both boundaries are exercised.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int   phase;
      logic r, d, rd, c;
      phase = (i / 200) % 3;
      r  = ($urandom_range(0, 299) == 0);
      d  = (phase == 0) ? ($urandom_range(0, 9) < 8) :
           (phase == 1) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 1) == 1);
      rd = (phase == 0) ? ($urandom_range(0, 9) < 2) :
           (phase == 1) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 1) == 1);
      c  = ($urandom_range(0, 19) == 0);
      apply_stimulus(r, d, 8'($urandom), rd, c);
      check_output();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
